// File: rtl/vip_adapter_pkg.sv
// Shared types and constants for the VIP pipeline adapter.
// Optional bypass path is enabled with VIP_ADAPTER_BYPASS_EN (see vip_pipeline_adapter).
package vip_adapter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CTRL   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    localparam logic [15:0] DEFAULT_WIDTH  = 16'd640;
    localparam logic [15:0] DEFAULT_HEIGHT = 16'd480;

    function automatic int unsigned beat_width(input int unsigned bps, input int unsigned spb);
        return bps * spb;
    endfunction

endpackage

// File: rtl/vip_skid_fifo.sv
// Synchronous FIFO with registered occupancy count; head word is visible on dout.
module vip_skid_fifo #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/vip_pipeline_adapter.sv
// Flow-control shell between VIP decoder/encoder wrappers and a FIFO-fronted pixel pipeline.
// Define VIP_ADAPTER_BYPASS_EN to add the per-frame bypass input.
module vip_pipeline_adapter
    import vip_adapter_pkg::*;
#(
    parameter int unsigned BITS_PER_SYMBOL  = 8,
    parameter int unsigned SYMBOLS_PER_BEAT = 3,
    parameter int unsigned PROC_OUT_BITS    = 8,
    parameter int unsigned OUT_DEPTH        = 16,
    parameter int unsigned CNT_W            = 32
) (
    input  logic                                        clk,
    input  logic                                        rst,
`ifdef VIP_ADAPTER_BYPASS_EN
    input  logic                                        bypass,
`endif
    input  logic                                        stall_in,
    output logic                                        read,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_in,
    input  logic                                        end_of_video,
    input  logic [15:0]                                 width_in,
    input  logic [15:0]                                 height_in,
    input  logic [3:0]                                  interlaced_in,
    input  logic                                        vip_ctrl_valid,
    input  logic                                        stall_out,
    output logic                                        write,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_out,
    output logic                                        end_of_video_out,
    output logic [15:0]                                 width_out,
    output logic [15:0]                                 height_out,
    output logic [3:0]                                  interlaced_out,
    input  logic                                        vip_ctrl_busy,
    output logic                                        vip_ctrl_send,
    output logic                                        proc_wr_en,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] proc_din,
    input  logic                                        proc_full,
    output logic                                        proc_rd_en,
    input  logic [PROC_OUT_BITS-1:0]                    proc_dout,
    input  logic                                        proc_empty
);
    localparam int unsigned BEAT_W = beat_width(BITS_PER_SYMBOL, SYMBOLS_PER_BEAT);
    localparam int unsigned FW     = BEAT_W + 1;
    localparam int unsigned CW     = $clog2(OUT_DEPTH) + 1;

    state_t                     state;
    state_t                     state_nx;
    logic                       send_nx;
    logic                       start;
    logic                       accept;
    logic                       xfer;
    logic                       byp;
    logic [CNT_W-1:0]           frame_px;
    logic [CNT_W-1:0]           in_cnt;
    logic [CNT_W-1:0]           push_cnt;
    logic [CNT_W-1:0]           out_target;
    logic [CNT_W-1:0]           target_c;
    logic                       in_done;
    logic [CW-1:0]              in_flight;
    logic                       pend_valid;
    logic [BEAT_W-1:0]          pend_data;
    logic [BITS_PER_SYMBOL-1:0] sym;
    logic                       skid_full;
    logic                       f_push;
    logic [FW-1:0]              f_din;
    logic [FW-1:0]              f_dout;
    logic                       f_full;
    logic                       f_empty;
    logic [CW-1:0]              f_count;

    assign start  = (state == ST_IDLE) & vip_ctrl_valid & (|width_in) & (|height_in);
    assign accept = read & ~stall_in;
    assign xfer   = write & ~stall_out;

    // Frame sequencing: latch geometry, send control packet, stream until the last output beat.
    always_comb begin
        state_nx = state;
        send_nx  = 1'b0;
        case (state)
            ST_IDLE:   if (start) state_nx = ST_CTRL;
            ST_CTRL: begin
                if (!vip_ctrl_busy) begin
                    send_nx  = 1'b1;
                    state_nx = ST_STREAM;
                end
            end
            ST_STREAM: if (xfer && f_dout[BEAT_W]) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            vip_ctrl_send <= 1'b0;
        end else begin
            state         <= state_nx;
            vip_ctrl_send <= send_nx;
        end
    end

`ifdef VIP_ADAPTER_BYPASS_EN
    always_ff @(posedge clk) begin
        if (rst)        byp <= 1'b0;
        else if (start) byp <= bypass;
    end
`else
    assign byp = 1'b0;
`endif

    // Credit-limited input request; in_flight covers the pipeline, the pending pop and the skid FIFO.
    assign read       = (state == ST_STREAM) & ~in_done & ~proc_full & (in_flight < CW'(OUT_DEPTH));
    assign proc_wr_en = accept & ~byp;
    assign proc_din   = data_in;

    // The in-flight pop occupies a reserved slot so the FIFO never overflows.
    assign skid_full  = f_full | ((f_count + CW'(pend_valid)) >= CW'(OUT_DEPTH));
    assign proc_rd_en = ~proc_empty & ~skid_full & ~byp;
    assign sym        = BITS_PER_SYMBOL'(proc_dout);

    // An early end_of_video retargets the frame in the same cycle it is accepted.
    assign target_c = (accept && end_of_video) ? in_cnt + CNT_W'(1) : out_target;
    assign f_push   = byp ? accept : pend_valid;
    assign f_din    = {(push_cnt + CNT_W'(1) == target_c), (byp ? data_in : pend_data)};

    always_ff @(posedge clk) begin
        if (rst) begin
            width_out      <= DEFAULT_WIDTH;
            height_out     <= DEFAULT_HEIGHT;
            interlaced_out <= '0;
            frame_px       <= '0;
            out_target     <= '0;
            in_cnt         <= '0;
            push_cnt       <= '0;
            in_done        <= 1'b0;
            in_flight      <= '0;
            pend_valid     <= 1'b0;
            pend_data      <= '0;
        end else begin
            if (start) begin
                width_out      <= width_in;
                height_out     <= height_in;
                interlaced_out <= interlaced_in;
                frame_px       <= CNT_W'(width_in) * CNT_W'(height_in);
                out_target     <= CNT_W'(width_in) * CNT_W'(height_in);
                in_cnt         <= '0;
                push_cnt       <= '0;
                in_done        <= 1'b0;
            end else begin
                if (accept) begin
                    in_cnt <= in_cnt + CNT_W'(1);
                    if ((in_cnt + CNT_W'(1) == frame_px) || end_of_video) in_done <= 1'b1;
                    if (end_of_video) out_target <= in_cnt + CNT_W'(1);
                end
                if (f_push) push_cnt <= push_cnt + CNT_W'(1);
            end
            in_flight  <= in_flight + CW'(accept) - CW'(xfer);
            pend_valid <= proc_rd_en;
            if (proc_rd_en) pend_data <= {SYMBOLS_PER_BEAT{sym}};
        end
    end

    vip_skid_fifo #(
        .WIDTH (FW),
        .DEPTH (OUT_DEPTH)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (f_push),
        .din   (f_din),
        .pop   (xfer),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );

    assign write            = ~f_empty;
    assign data_out         = f_empty ? '0 : f_dout[BEAT_W-1:0];
    assign end_of_video_out = ~f_empty & f_dout[BEAT_W];

endmodule
